gray_code_pipe: RTL and testbench
=================================

Name: gray_code_pipe

Overview:
- Parametrised, registered Gray/binary converter with a valid/ready handshake. Successor to the fixed 4-bit combinational Gray-to-binary block.
- Converts in either direction, selected per transaction.
- In Gray-to-binary mode, checks that successive accepted Gray codes differ by at most one bit, and counts violations.
- Sits between encoder/counter sampling logic and downstream consumers (display, arithmetic).

Parameters:
- WIDTH, 4, data width in bits; legal values 2..32.
- ERR_CNT_W, 8, width of the saturating step-error counter; legal values 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode_in  input  1  0 = Gray->binary, 1 = binary->Gray; sampled on input transfer.
- data_in  input  WIDTH  input code.
- valid_in  input  1  data_in/mode_in valid.
- ready_out  output  1  block can accept input this cycle.
- data_out  output  WIDTH  converted result.
- valid_out  output  1  data_out valid.
- ready_in  input  1  downstream accepts data_out this cycle.
- step_err_out  output  1  step violation flag, aligned with data_out.
- err_count_out  output  ERR_CNT_W  saturating count of step violations.
- clr_in  input  1  synchronous clear of history and err_count_out.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, valid_out=0, step_err_out=0, err_count_out=0. Internal prev_gray=0, has_prev=0, prev_mode=0. ready_out is combinational, so it is 1 while reset is asserted.
- ready_out = !valid_out || ready_in (combinational). No combinational path from valid_in to ready_out.
- Input transfer: valid_in && ready_out at the rising edge.
- Output transfer: valid_out && ready_in at the rising edge.
- Latency: exactly 1 cycle from input transfer to valid_out=1 with the result.
- Full throughput (1 transfer/cycle) while ready_in=1.
- On input transfer:
  - data_out, step_err_out and valid_out=1 are loaded.
  - Gray->binary: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0.
  - Binary->Gray: g = b ^ (b >> 1).
- Output transfer without an input transfer: valid_out=0. data_out and step_err_out keep their last values; they are don't-care while valid_out=0.
- Hold: while valid_out && !ready_in, data_out, step_err_out and valid_out are stable. ready_out=0, so no input is accepted.
- Step check (mode_in=0 transfers only):
  - dist = popcount(data_in ^ prev_gray).
  - step_err = has_prev && (dist >= 2). dist 0 (no motion) and dist 1 are legal.
  - After the transfer: prev_gray=data_in, has_prev=1.
  - A violation increments err_count_out, saturating at 2^ERR_CNT_W-1; no wrap.
- mode_in=1 transfers: step_err=0. History is cleared (has_prev=0), so the next Gray transfer is never flagged.
- clr_in=1: has_prev=0 and err_count_out=0 at the next edge.
- clr_in coincident with an input transfer: the conversion proceeds normally and step_err=0 for that transfer. No increment. has_prev ends at 1 with prev_gray=data_in if mode_in=0, otherwise 0.
- clr_in coincident with a hold: the held output is unaffected.
- Reset mid-transaction: the pending output is discarded (valid_out=0). There is no replay.
- All internal state is flops on clk/rst_n. There are no latches and no multicycle paths.

Test Plan:
- Reset, WIDTH=4, ready_in=1: transfer mode=0, data_in=4'b0110 -> next cycle valid_out=1, data_out=4'b0100, step_err_out=0.
- Transfer mode=1, data_in=4'b1011 -> data_out=4'b1110 after 1 cycle. Back-to-back transfers of 0..15 in mode=1 -> output stream 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, one per cycle.
- Mode=0 Gray sequence 0000,0001,0011,0011,0000,0001:
  - step_err_out flags 0,0,0,0,1,0.
  - err_count_out=1.
  - A mode=1 transfer then mode=0 data_in=1111 -> step_err_out=0.
- Backpressure: valid_out=1, ready_in=0 for 3 cycles with valid_in=1 -> ready_out=0 and data_out stable throughout. When ready_in rises, ready_out=1 in that same cycle and the pending input is accepted at that edge.
- Saturation with ERR_CNT_W=2: alternate 0000/1111 in mode=0 for 6 transfers -> err_count_out sequence 0,1,2,3,3,3. clr_in=1 with a transfer of 0001 -> err_count_out=0, step_err_out=0.
- Assert rst_n=0 asynchronously while valid_out=1 and ready_in=0 -> valid_out=0 and err_count_out=0 immediately. After release, the first mode=0 transfer of 1111 -> step_err_out=0.

Source files
------------

// File: rtl/gray_code_pipe.sv
// rtl/gray_code_pipe.sv - registered Gray/binary converter with valid/ready handshake
// and a Gray single-step checker that feeds a saturating violation counter.
module gray_code_pipe #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode_in,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 step_err_out,
  output logic [ERR_CNT_W-1:0] err_count_out,
  input  logic                 clr_in
);

  localparam logic [WIDTH-1:0]     DATA_ONE = 1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  logic             in_xfer;
  logic             out_xfer;
  logic             has_prev;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             step_err;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign ready_out = !valid_out || ready_in;
  assign in_xfer   = valid_in && ready_out;
  assign out_xfer  = valid_out && ready_in;

  assign conv = mode_in ? (data_in ^ (data_in >> 1)) : gray_to_bin(data_in);

  // Two or more differing bits: clearing the lowest set bit leaves something behind.
  assign diff      = data_in ^ prev_gray;
  assign multi_bit = |(diff & (diff - DATA_ONE));
  assign step_err  = !mode_in && has_prev && multi_bit && !clr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      valid_out    <= 1'b0;
      step_err_out <= 1'b0;
    end else if (in_xfer) begin
      data_out     <= conv;
      valid_out    <= 1'b1;
      step_err_out <= step_err;
    end else if (out_xfer) begin
      valid_out    <= 1'b0;
    end
  end

  // A Gray transfer re-seeds history even under clr_in; anything else only clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray     <= '0;
      has_prev      <= 1'b0;
      err_count_out <= '0;
    end else begin
      if (in_xfer && !mode_in) begin
        prev_gray <= data_in;
        has_prev  <= 1'b1;
      end else if (in_xfer || clr_in) begin
        has_prev  <= 1'b0;
      end

      if (clr_in) begin
        err_count_out <= '0;
      end else if (in_xfer && step_err && err_count_out != CNT_MAX) begin
        err_count_out <= err_count_out + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_gray_code_pipe.sv
// tb/tb_gray_code_pipe.sv - directed self-checking bench for gray_code_pipe
// (WIDTH=4, ERR_CNT_W=2 so saturation is reachable quickly).
module tb_gray_code_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_in;
  logic [3:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [3:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       step_err_out;
  logic [1:0] err_count_out;
  logic       clr_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_code_pipe #(.WIDTH(4), .ERR_CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_in      (mode_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .step_err_out (step_err_out),
    .err_count_out(err_count_out),
    .clr_in       (clr_in)
  );

  task automatic xfer(input logic m, input logic [3:0] d, input logic clr);
    valid_in = 1'b1;
    mode_in  = m;
    data_in  = d;
    clr_in   = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clr_in   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; mode_in = 1'b0; data_in = '0;
    ready_in = 1'b1; clr_in = 1'b0;
    #12;
    checks++;
    if ({valid_out, data_out, step_err_out, err_count_out, ready_out} !== {1'b0, 4'b0, 1'b0, 2'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%b e=%b c=%0d r=%b want v=0 d=0000 e=0 c=0 r=1",
               valid_out, data_out, step_err_out, err_count_out, ready_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_g2b_basic();
    xfer(1'b0, 4'b0110, 1'b0);
    checks++;
    if ({valid_out, data_out, step_err_out} !== {1'b1, 4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL g2b_0110 got v=%b d=%b e=%b want v=1 d=0100 e=0", valid_out, data_out, step_err_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                               4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    xfer(1'b1, 4'b1011, 1'b0);
    checks++;
    if (data_out !== 4'b1110) begin
      errors++;
      $display("FAIL b2g_1011 got %b want 1110", data_out);
    end
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 4'(i), 1'b0);
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp_g[i]) begin
        errors++;
        $display("FAIL b2g_stream[%0d] got v=%b d=%0d want v=1 d=%0d", i, valid_out, data_out, exp_g[i]);
      end
    end
  endtask

  task automatic test_step_check();
    logic [3:0] seq  [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0000, 4'b0001};
    logic [3:0] bin  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic       flag [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, seq[i], 1'b0);
      checks++;
      if (step_err_out !== flag[i] || data_out !== bin[i]) begin
        errors++;
        $display("FAIL step_seq[%0d] got e=%b d=%b want e=%b d=%b", i, step_err_out, data_out, flag[i], bin[i]);
      end
    end
    checks++;
    if (err_count_out !== 2'd1) begin
      errors++;
      $display("FAIL step_count got %0d want 1", err_count_out);
    end
    xfer(1'b1, 4'b0000, 1'b0);
    xfer(1'b0, 4'b1111, 1'b0);
    checks++;
    if (step_err_out !== 1'b0 || data_out !== 4'b1010) begin
      errors++;
      $display("FAIL history_cleared got e=%b d=%b want e=0 d=1010", step_err_out, data_out);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    ready_in = 1'b0;
    xfer(1'b1, 4'b0011, 1'b0);
    valid_in = 1'b1; mode_in = 1'b1; data_in = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      clr_in = (i == 1);
      @(posedge clk); #1;
      checks++;
      if ({ready_out, valid_out, data_out} !== {1'b0, 1'b1, 4'b0010}) begin
        errors++;
        $display("FAIL hold[%0d] got r=%b v=%b d=%b want r=0 v=1 d=0010", i, ready_out, valid_out, data_out);
      end
    end
    clr_in = 1'b0;
    checks++;
    if (err_count_out !== 2'd0) begin
      errors++;
      $display("FAIL clr_during_hold got %0d want 0", err_count_out);
    end
    ready_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL ready_follows got %b want 1", ready_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== 4'b0110) begin
      errors++;
      $display("FAIL pending_accepted got v=%b d=%b want v=1 d=0110", valid_out, data_out);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL drain got v=%b want 0", valid_out);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, (i % 2 == 0) ? 4'b0000 : 4'b1111, 1'b0);
      checks++;
      if (err_count_out !== exp_cnt[i] || step_err_out !== (i != 0)) begin
        errors++;
        $display("FAIL sat[%0d] got c=%0d e=%b want c=%0d e=%b", i, err_count_out, step_err_out, exp_cnt[i], i != 0);
      end
    end
    xfer(1'b0, 4'b0001, 1'b1);
    checks++;
    if (err_count_out !== 2'd0 || step_err_out !== 1'b0 || data_out !== 4'b0001) begin
      errors++;
      $display("FAIL clr_with_xfer got c=%0d e=%b d=%b want c=0 e=0 d=0001", err_count_out, step_err_out, data_out);
    end
    xfer(1'b0, 4'b0010, 1'b0);
    checks++;
    if (err_count_out !== 2'd1 || step_err_out !== 1'b1) begin
      errors++;
      $display("FAIL history_after_clr got c=%0d e=%b want c=1 e=1", err_count_out, step_err_out);
    end
  endtask

  task automatic test_async_reset();
    ready_in = 1'b0;
    xfer(1'b1, 4'b0101, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_out, err_count_out, ready_out} !== {1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got v=%b c=%0d r=%b want v=0 c=0 r=1", valid_out, err_count_out, ready_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL no_replay got v=%b want 0", valid_out);
    end
    xfer(1'b0, 4'b1111, 1'b0);
    checks++;
    if (step_err_out !== 1'b0 || data_out !== 4'b1010) begin
      errors++;
      $display("FAIL first_after_reset got e=%b d=%b want e=0 d=1010", step_err_out, data_out);
    end
    xfer(1'b0, 4'b0000, 1'b0);
    checks++;
    if (step_err_out !== 1'b1 || err_count_out !== 2'd1) begin
      errors++;
      $display("FAIL second_after_reset got e=%b c=%0d want e=1 c=1", step_err_out, err_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_g2b_basic();
    test_back_to_back();
    test_step_check();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
